// File: rtl/fifo_sync_param_if.sv
// Handshake/bus bundle for fifo_sync_param: the producer/consumer side uses master, the FIFO uses slave.
interface fifo_sync_param_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
);
   logic [DATA_W-1:0] Data_In;
   logic              Write;
   logic              Read;
   logic [ADDR_W:0]   AFull_Thresh;
   logic [ADDR_W:0]   AEmpty_Thresh;
   logic              Err_Clr;
   logic [DATA_W-1:0] Data_Out;
   logic              Data_Valid;
   logic [3:0]        Fifo_Status;
   logic [ADDR_W:0]   Fill_Count;
   logic              Overflow;
   logic              Underflow;

   modport master (
      output Data_In, Write, Read, AFull_Thresh, AEmpty_Thresh, Err_Clr,
      input  Data_Out, Data_Valid, Fifo_Status, Fill_Count, Overflow, Underflow
   );

   modport slave (
      input  Data_In, Write, Read, AFull_Thresh, AEmpty_Thresh, Err_Clr,
      output Data_Out, Data_Valid, Fifo_Status, Fill_Count, Overflow, Underflow
   );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with registered read data, runtime almost-full/empty thresholds.
// Define FIFO_ERR_FLAGS_EN to build the sticky Overflow/Underflow error registers.
module fifo_sync_param #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic             Clk,
   input  logic             Reset,
   fifo_sync_param_if.slave bus
);
   localparam int              DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   cnt;
   logic              empty, full, rd_acc, wr_acc;

   assign empty  = (cnt == '0);
   assign full   = (cnt == DEPTH_C);
   // No read bypass when empty; a full FIFO still takes a write if a read frees a slot the same edge.
   assign rd_acc = bus.Read & ~empty;
   assign wr_acc = bus.Write & (~full | rd_acc);

   always_ff @(posedge Clk) begin
      if (wr_acc && !Reset) mem[wr_ptr] <= bus.Data_In;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         cnt            <= '0;
         bus.Data_Out   <= '0;
         bus.Data_Valid <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) begin
            rd_ptr       <= rd_ptr + 1'b1;
            bus.Data_Out <= mem[rd_ptr];
         end
         bus.Data_Valid <= rd_acc;
         case ({wr_acc, rd_acc})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign bus.Fill_Count  = cnt;
   assign bus.Fifo_Status = {full, (cnt >= bus.AFull_Thresh), (cnt <= bus.AEmpty_Thresh), empty};

`ifdef FIFO_ERR_FLAGS_EN
   logic ovf_set, unf_set;
   assign ovf_set = bus.Write & full & ~rd_acc;
   assign unf_set = bus.Read & empty;

   // Set wins over a same-cycle clear so no error event is lost.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         bus.Overflow  <= 1'b0;
         bus.Underflow <= 1'b0;
      end else begin
         bus.Overflow  <= ovf_set | (bus.Overflow  & ~bus.Err_Clr);
         bus.Underflow <= unf_set | (bus.Underflow & ~bus.Err_Clr);
      end
   end
`else
   logic unused_err_clr;
   assign unused_err_clr = bus.Err_Clr;
   assign bus.Overflow   = 1'b0;
   assign bus.Underflow  = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: queue-based reference model checked every cycle plus literal checks.
module tb_fifo_sync_param;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 8;

   logic Clk, Reset;
   fifo_sync_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
   fifo_sync_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   int errors = 0;
   int checks = 0;

   logic [7:0] q [$];
   logic [7:0] m_dout;
   logic       m_dv, m_ovf, m_unf;
`ifdef FIFO_ERR_FLAGS_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour from the FIFO rules, evaluated with the inputs present at the edge.
   task automatic model_step();
      bit was_empty, was_full, rd, wr;
      if (Reset) begin
         q.delete();
         m_dout = '0; m_dv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
         return;
      end
      was_empty = (q.size() == 0);
      was_full  = (q.size() == DEPTH);
      rd = bus.Read && !was_empty;
      wr = bus.Write && (!was_full || rd);
      m_dv = rd;
      if (rd) m_dout = q.pop_front();
      if (wr) q.push_back(bus.Data_In);
      if (ERR_EN) begin
         m_ovf = (bus.Write && was_full && !rd) || (m_ovf && !bus.Err_Clr);
         m_unf = (bus.Read && was_empty) || (m_unf && !bus.Err_Clr);
      end
   endtask

   task automatic check_model();
      int n;
      logic [3:0] st;
      n  = q.size();
      st = {n == DEPTH, n >= int'(bus.AFull_Thresh), n <= int'(bus.AEmpty_Thresh), n == 0};
      chk("fill_count", bus.Fill_Count, n);
      chk("fifo_status", bus.Fifo_Status, st);
      chk("data_valid", bus.Data_Valid, m_dv);
      chk("data_out", bus.Data_Out, m_dout);
      chk("overflow", bus.Overflow, m_ovf);
      chk("underflow", bus.Underflow, m_unf);
   endtask

   task automatic cyc(input bit w, input bit r, input logic [7:0] d, input bit clr = 0, input bit rst = 0);
      bus.Write = w; bus.Read = r; bus.Data_In = d; bus.Err_Clr = clr; Reset = rst;
      @(posedge Clk);
      model_step();
      @(negedge Clk);
      check_model();
   endtask

   task automatic fill_1_to_8();
      for (int i = 1; i <= 8; i++) cyc(1, 0, 8'(i));
   endtask

   initial begin
      bus.Write = 0; bus.Read = 0; bus.Data_In = '0; bus.Err_Clr = 0; Reset = 1;
      bus.AFull_Thresh = 4'd6; bus.AEmpty_Thresh = 4'd1;
      q.delete(); m_dout = '0; m_dv = 0; m_ovf = 0; m_unf = 0;
      @(negedge Clk);
      cyc(0, 0, 0, 0, 1);
      chk("reset_status", bus.Fifo_Status, 4'b0011);
      chk("reset_count", bus.Fill_Count, 0);

      // 1: fill to full
      fill_1_to_8();
      chk("t1_count", bus.Fill_Count, 8);
      chk("t1_status", bus.Fifo_Status, 4'b1100);

      // 2: drain, data one cycle after each read
      for (int i = 1; i <= 8; i++) begin
         cyc(0, 1, 0);
         chk("t2_dv", bus.Data_Valid, 1);
         chk("t2_dout", bus.Data_Out, i);
      end
      cyc(0, 0, 0);
      chk("t2_dv_idle", bus.Data_Valid, 0);
      chk("t2_status", bus.Fifo_Status, 4'b0011);

      // 3: simultaneous read+write while full
      fill_1_to_8();
      cyc(1, 1, 8'hA5);
      chk("t3_count", bus.Fill_Count, 8);
      chk("t3_oldest", bus.Data_Out, 8'h01);
      for (int i = 0; i < 8; i++) cyc(0, 1, 0);
      chk("t3_last", bus.Data_Out, 8'hA5);

      // 4: simultaneous read+write while empty
      cyc(1, 1, 8'h3C);
      chk("t4_dv", bus.Data_Valid, 0);
      chk("t4_count", bus.Fill_Count, 1);
      cyc(0, 1, 0);
      chk("t4_dout", bus.Data_Out, 8'h3C);
      chk("t4_dv2", bus.Data_Valid, 1);

      // 5: error flags
      fill_1_to_8();
      cyc(1, 0, 8'hEE);
      chk("t5_ovf", bus.Overflow, int'(ERR_EN));
      chk("t5_count", bus.Fill_Count, 8);
      for (int i = 0; i < 8; i++) cyc(0, 1, 0);
      chk("t5_data_kept", bus.Data_Out, 8'h08);
      cyc(0, 1, 0);
      chk("t5_unf", bus.Underflow, int'(ERR_EN));
      cyc(0, 1, 0, 1);
      chk("t5_set_over_clr", bus.Underflow, int'(ERR_EN));
      cyc(0, 0, 0, 1);
      chk("t5_clr_ovf", bus.Overflow, 0);
      chk("t5_clr_unf", bus.Underflow, 0);

      // 6: 20 writes interleaved with reads across wrap, reset mid-burst
      for (int i = 0, nw = 0; nw < 20; i++) begin
         bit w, r;
         w = 1'b1; r = (i % 3) != 0;
         cyc(w, r, 8'($urandom), 0, nw == 14);
         nw++;
      end
      cyc(0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0);
      cyc(0, 0, 0, 0, 1);
      chk("t6_count", bus.Fill_Count, 0);
      chk("t6_empty", bus.Fifo_Status[0], 1);

      // randomized soak with moving thresholds
      for (int i = 0; i < 1500; i++) begin
         if (i % 16 == 0) begin
            bus.AFull_Thresh  = 4'($urandom_range(0, 9));
            bus.AEmpty_Thresh = 4'($urandom_range(0, 9));
         end
         cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, 8'($urandom),
             $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
      end
      bus.AFull_Thresh = 4'd0;
      cyc(0, 0, 0, 0, 1);
      chk("afull_zero", bus.Fifo_Status[2], 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
